// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback path: active-low digit patterns,
// frame FSM states and the accumulator working width.
package seg7_pkg;

    localparam int unsigned ACC_W = 36;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational 7-segment (gfedcba) to decimal decoder; unknown patterns and
// blanks report digit 0 with is_digit low.
module seg7_digit_decode
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       is_digit,
    output logic       is_blank
);

    logic [6:0] norm;

    always_comb begin
        norm     = ACTIVE_LOW ? pattern : ~pattern;
        digit    = '0;
        is_digit = 1'b1;
        is_blank = 1'b0;
        case (norm)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Collects a frame of 7-segment beats (MS digit first), accumulates the decimal
// value with 32-bit saturation and returns it with an error flag and digit count.
module seg7_frame_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 10,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        seg_valid,
    output logic        seg_ready,
    input  logic [6:0]  seg_in,
    input  logic        seg_last,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [31:0] result,
    output logic        result_error,
    output logic [3:0]  digit_count
);

    state_t            state;
    logic [31:0]       acc;
    logic [3:0]        count;
    logic              err;

    logic [3:0]        digit;
    logic              is_digit;
    logic              is_blank;

    logic [ACC_W-1:0]  prod;
    logic [31:0]       acc_next;
    logic [3:0]        count_next;
    logic              err_next;

    seg7_digit_decode #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_decode (
        .pattern  (seg_in),
        .digit    (digit),
        .is_digit (is_digit),
        .is_blank (is_blank)
    );

    // Effect of the current beat on the frame state, used only when the beat is taken.
    // A saturated acc always overflows again on the next digit, so it stays pinned.
    always_comb begin
        acc_next   = acc;
        count_next = count;
        err_next   = err;
        prod       = ACC_W'(acc) * ACC_W'(10) + ACC_W'(digit);
        if (is_blank) begin
            if (count != '0)
                err_next = 1'b1;
        end else begin
            if (!is_digit)
                err_next = 1'b1;
            if (prod > ACC_W'(32'hFFFF_FFFF)) begin
                acc_next = '1;
                err_next = 1'b1;
            end else begin
                acc_next = prod[31:0];
            end
            count_next = (count == 4'hF) ? 4'hF : count + 4'd1;
            if (32'(count_next) > MAX_DIGITS)
                err_next = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            err          <= 1'b0;
            seg_ready    <= 1'b1;
            result_valid <= 1'b0;
            result       <= '0;
            result_error <= 1'b0;
            digit_count  <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (seg_valid && seg_ready) begin
                        acc   <= acc_next;
                        count <= count_next;
                        err   <= err_next;
                        if (seg_last) begin
                            state        <= DONE;
                            seg_ready    <= 1'b0;
                            result_valid <= 1'b1;
                            result       <= acc_next;
                            digit_count  <= count_next;
                            result_error <= err_next || (count_next == '0);
                        end else if (count_next != '0) begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        seg_ready    <= 1'b1;
                        result_valid <= 1'b0;
                        acc          <= '0;
                        count        <= '0;
                        err          <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Bench for seg7_frame_decoder: directed frames with literal expectations, then
// random frames checked every cycle against a digit-string reference model.
module tb_seg7_frame_decoder;

    localparam int unsigned MAX_DIGITS = 10;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] BAD   = 7'b1010101;
    localparam logic [6:0] SEGS [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0010000};

    typedef logic [6:0] beat_q_t [$];
    typedef struct packed {
        logic [31:0] v;
        logic        e;
        logic [3:0]  c;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        seg_valid = 1'b0;
    logic        seg_ready;
    logic [6:0]  seg_in = BLANK;
    logic        seg_last = 1'b0;
    logic        result_valid;
    logic        result_ready = 1'b1;
    logic [31:0] result;
    logic        result_error;
    logic [3:0]  digit_count;

    int n_tests = 0;
    int n_fail  = 0;
    int rr_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit pending = 1'b0;
    beat_q_t cur_beats;
    exp_t exp_q [$];
    exp_t got_q [$];

    seg7_frame_decoder #(
        .MAX_DIGITS(MAX_DIGITS),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .seg_valid    (seg_valid),
        .seg_ready    (seg_ready),
        .seg_in       (seg_in),
        .seg_last     (seg_last),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .result_error (result_error),
        .digit_count  (digit_count)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endfunction

    function automatic int lookup(input logic [6:0] p);
        for (int k = 0; k < 10; k++)
            if (p == SEGS[k]) return k;
        if (p == BLANK) return -1;
        return -2;
    endfunction

    // Reference: value of the digit string after dropping leading blanks.
    function automatic exp_t model(input beat_q_t b);
        longint unsigned val = 0;
        int cnt = 0;
        int d;
        bit err = 1'b0;
        bit sat = 1'b0;
        exp_t r;
        foreach (b[i]) begin
            d = lookup(b[i]);
            if (d == -1) begin
                if (cnt > 0) err = 1'b1;
            end else begin
                cnt++;
                if (d == -2) begin
                    err = 1'b1;
                    d = 0;
                end
                if (!sat) begin
                    val = val * 10 + longint'(d);
                    if (val > 64'hFFFF_FFFF) sat = 1'b1;
                end
            end
        end
        if (sat) begin
            err = 1'b1;
            val = 64'hFFFF_FFFF;
        end
        if (cnt == 0 || cnt > int'(MAX_DIGITS)) err = 1'b1;
        r.v = val[31:0];
        r.e = err;
        r.c = (cnt > 15) ? 4'hF : 4'(cnt);
        return r;
    endfunction

    function automatic beat_q_t mk(input string s);
        beat_q_t q;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "b")      q.push_back(BLANK);
            else if (s[i] == "x") q.push_back(BAD);
            else                  q.push_back(SEGS[int'(s[i]) - 48]);
        end
        return q;
    endfunction

    function automatic beat_q_t rand_frame();
        beat_q_t q;
        int n;
        int r;
        logic [6:0] p;
        if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 2)) q.push_back(BLANK);
        n = $urandom_range(0, 11);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                q.push_back(BLANK);
            end else if (r < 6) begin
                p = 7'($urandom_range(0, 127));
                q.push_back((lookup(p) == -2) ? p : BAD);
            end else begin
                q.push_back(SEGS[$urandom_range(0, 9)]);
            end
        end
        if (q.size() == 0) q.push_back(SEGS[$urandom_range(0, 9)]);
        return q;
    endfunction

    // Monitor and compare: tracks the handshake protocol and checks every cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                cur_beats.delete();
                exp_q.delete();
                pending = 1'b0;
            end else begin
                chk("result_valid", 32'(result_valid), 32'(pending));
                chk("seg_ready", 32'(seg_ready), 32'(!pending));
                if (pending) begin
                    if (exp_q.size() == 0) begin
                        chk("result_queue_empty", 32'd1, 32'd0);
                    end else begin
                        chk("result", result, exp_q[0].v);
                        chk("result_error", 32'(result_error), 32'(exp_q[0].e));
                        chk("digit_count", 32'(digit_count), 32'(exp_q[0].c));
                    end
                    if (result_ready) begin
                        got_q.push_back('{v: result, e: result_error, c: digit_count});
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        pending = 1'b0;
                    end
                end else if (seg_valid) begin
                    cur_beats.push_back(seg_in);
                    if (seg_last) begin
                        exp_q.push_back(model(cur_beats));
                        cur_beats.delete();
                        pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (rr_mode)
                0:       result_ready = 1'b1;
                1:       result_ready = ($urandom_range(0, 2) != 0);
                default: result_ready = 1'b0;
            endcase
        end
    end

    task automatic send_beat(input logic [6:0] p, input bit last);
        int n = 0;
        bit took = 1'b0;
        seg_valid = 1'b1;
        seg_in    = p;
        seg_last  = last;
        while (!took && n < 200) begin
            @(negedge clock);
            took = seg_ready;
            @(posedge clock);
            #1;
            n++;
        end
        chk("beat_accept_timeout", 32'(took), 32'd1);
        seg_valid = 1'b0;
        seg_last  = 1'b0;
    endtask

    task automatic send_frame(input beat_q_t q, input bit gaps);
        foreach (q[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                seg_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clock);
                #1;
            end
            send_beat(q[i], i == q.size() - 1);
        end
    endtask

    task automatic expect_next(input string name, input logic [31:0] v, input bit e, input logic [3:0] c);
        int n = 0;
        exp_t g;
        while (got_q.size() == 0 && n < 300) begin
            @(posedge clock);
            n++;
        end
        if (got_q.size() == 0) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            g = got_q.pop_front();
            chk({name, "_value"}, g.v, v);
            chk({name, "_error"}, 32'(g.e), 32'(e));
            chk({name, "_count"}, 32'(g.c), 32'(c));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_seg_ready"}, 32'(seg_ready), 32'd1);
        chk({name, "_result_valid"}, 32'(result_valid), 32'd0);
        chk({name, "_result"}, result, 32'd0);
        chk({name, "_result_error"}, 32'(result_error), 32'd0);
        chk({name, "_digit_count"}, 32'(digit_count), 32'd0);
    endtask

    initial begin
        exp_t m;
        int n;

        // Pin the reference model with hand-computed frames.
        m = model(mk("237"));
        chk("model_237", {m.v[31:0]}, 32'd237);
        chk("model_237_cnt", 32'(m.c), 32'd3);
        m = model(mk("bb10"));
        chk("model_lead_blank", m.v, 32'd10);
        chk("model_lead_blank_err", 32'(m.e), 32'd0);
        m = model(mk("1b0"));
        chk("model_mid_blank_err", 32'(m.e), 32'd1);
        m = model(mk("4x5"));
        chk("model_bad", m.v, 32'd405);
        m = model(mk("4294967296"));
        chk("model_ovf", m.v, 32'hFFFF_FFFF);
        m = model(mk("00000000001"));
        chk("model_eleven_err", 32'(m.e), 32'd1);

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_reset_outputs("reset_initial");

        send_frame(mk("237"), 1'b0);
        expect_next("t1_237", 32'd237, 1'b0, 4'd3);
        send_frame(mk("bb10"), 1'b0);
        expect_next("t2_lead_blank", 32'd10, 1'b0, 4'd2);
        send_frame(mk("1b0"), 1'b0);
        expect_next("t2_mid_blank", 32'd10, 1'b1, 4'd2);
        send_frame(mk("4x5"), 1'b0);
        expect_next("t3_bad", 32'd405, 1'b1, 4'd3);
        send_frame(mk("4294967296"), 1'b0);
        expect_next("t4_ovf", 32'hFFFF_FFFF, 1'b1, 4'd10);
        send_frame(mk("4294967295"), 1'b0);
        expect_next("t4_max", 32'hFFFF_FFFF, 1'b0, 4'd10);
        send_frame(mk("00000000001"), 1'b0);
        expect_next("t4_eleven", 32'd1, 1'b1, 4'd11);
        send_frame(mk("b"), 1'b0);
        expect_next("t4_no_digits", 32'd0, 1'b1, 4'd0);

        // Back-pressure: consumer stalls while the next frame's first beat waits.
        rr_mode = 2;
        #1;
        send_frame(mk("58"), 1'b0);
        fork
            begin
                repeat (5) @(posedge clock);
                rr_mode = 0;
            end
        join_none
        send_frame(mk("61"), 1'b0);
        expect_next("t5_held", 32'd58, 1'b0, 4'd2);
        expect_next("t5_next", 32'd61, 1'b0, 4'd2);

        send_beat(SEGS[1], 1'b0);
        send_beat(SEGS[2], 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_reset_outputs("reset_mid_frame");
        send_frame(mk("9"), 1'b0);
        expect_next("t6_after_reset", 32'd9, 1'b0, 4'd1);

        rr_mode = 1;
        for (int f = 0; f < 150; f++)
            send_frame(rand_frame(), 1'b1);
        n = 0;
        while (pending && n < 300) begin
            @(posedge clock);
            n++;
        end
        chk("final_drain_timeout", 32'(pending), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
